// File: rtl/jtag_host_if.sv
// Command/response channel between the system-side sequencer and jtag_host.
interface jtag_host_if #(
  parameter int MAX_LEN = 16,
  parameter int LW      = $clog2(MAX_LEN) + 1
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LW-1:0]      cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;

  // sequencer side
  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  // controller side
  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/jtag_host.sv
// Host-side JTAG controller: expands TAP-reset / IR / DR / idle commands
// into TCK/TMS/TDI sequences and returns captured TDO bits.
module jtag_host #(
  parameter int MAX_LEN = 16,
  parameter int CLK_DIV = 2,
  parameter int LW      = $clog2(MAX_LEN) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  jtag_host_if.slave  bus,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);
  // counter must also hold the 6-TCK reset list
  localparam int CW = (LW > 3) ? LW : 3;
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [1:0] OP_RST  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_DR   = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CW-1:0]      len_q, len_d;     // TCK count of the SHIFT state
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;     // TDO capture of the running command
  logic [MAX_LEN-1:0] rsp_q, rsp_d;     // last completed response
  logic [CW-1:0]      cnt_q, cnt_d;     // TCK index within current state
  logic [DW-1:0]      div_q, div_d;     // clk cycles within TCK half-period
  logic               tck_q, tck_d;
  logic               started_q, started_d;

  logic               active, accept, is_shift_op, tdi_bit;
  logic [CW-1:0]      last_cnt, len_clamp;

  assign active      = (state_q == S_PRE) || (state_q == S_SHIFT) || (state_q == S_POST);
  assign accept      = bus.cmd_valid && !active;
  assign is_shift_op = (op_q == OP_IR) || (op_q == OP_DR);
  assign tdi_bit     = |(data_q & (MAX_LEN'(1) << cnt_q));

  // clamp requested length into 1..MAX_LEN
  always_comb begin
    len_clamp = CW'(bus.cmd_len);
    if (bus.cmd_len == '0)                len_clamp = CW'(1);
    else if (bus.cmd_len > LW'(MAX_LEN))  len_clamp = CW'(MAX_LEN);
  end

  // index of the final TCK in each TCK-producing state
  always_comb begin
    last_cnt = '0;
    case (state_q)
      S_PRE:   last_cnt = (op_q == OP_IR) ? CW'(3) : CW'(2);
      S_SHIFT: last_cnt = len_q - CW'(1);
      S_POST:  last_cnt = CW'(1);
      default: last_cnt = '0;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_RST;
      len_q     <= '0;
      data_q    <= '0;
      cap_q     <= '0;
      rsp_q     <= '0;
      cnt_q     <= '0;
      div_q     <= '0;
      tck_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      len_q     <= len_d;
      data_q    <= data_d;
      cap_q     <= cap_d;
      rsp_q     <= rsp_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      tck_q     <= tck_d;
      started_q <= started_d;
    end
  end

  // next state: accept, pace TCK, capture on rise, advance bits on fall
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    len_d     = len_q;
    data_d    = data_q;
    cap_d     = cap_q;
    rsp_d     = rsp_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    tck_d     = tck_q;
    started_d = started_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d      = bus.cmd_op;
          data_d    = bus.cmd_data;
          cap_d     = '0;
          cnt_d     = '0;
          div_d     = '0;
          tck_d     = 1'b0;
          started_d = 1'b1;
          len_d     = (bus.cmd_op == OP_RST) ? CW'(6) : len_clamp;
          // reset and idle have no entry prefix
          state_d   = (bus.cmd_op == OP_IR || bus.cmd_op == OP_DR) ? S_PRE : S_SHIFT;
        end
      end
      default: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d = '0;
          tck_d = ~tck_q;
          if (!tck_q) begin
            // rising TCK: sample TDO for real shift bits
            if (state_q == S_SHIFT && is_shift_op)
              cap_d = cap_q | (MAX_LEN'(tdo) << cnt_q);
          end else if (cnt_q != last_cnt) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = '0;
            case (state_q)
              S_PRE:   state_d = S_SHIFT;
              S_SHIFT: begin
                if (is_shift_op) state_d = S_POST;
                else begin
                  state_d = S_DONE;
                  rsp_d   = cap_q;
                end
              end
              default: begin
                state_d = S_DONE;
                rsp_d   = cap_q;
              end
            endcase
          end
        end
      end
    endcase
  end

  // TMS/TDI follow state and bit index, which only move on falling TCK
  always_comb begin
    tms = 1'b0;
    tdi = 1'b0;
    case (state_q)
      S_IDLE:  tms = ~started_q;   // park high until the first command
      S_PRE:   tms = (op_q == OP_IR) ? (cnt_q < CW'(2)) : (cnt_q == '0);
      S_SHIFT: begin
        case (op_q)
          OP_RST:  tms = (cnt_q < CW'(5));
          OP_IDLE: tms = 1'b0;
          default: begin
            tms = (cnt_q == len_q - CW'(1));
            tdi = tdi_bit;
          end
        endcase
      end
      S_POST:  tms = (cnt_q == '0);
      default: tms = 1'b0;
    endcase
  end

  assign tck           = tck_q;
  assign bus.cmd_ready = !active;
  assign bus.busy      = active;
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_data  = rsp_q;
endmodule

// File: tb/tb_jtag_host.sv
// Randomized self-checking bench for jtag_host with a TAP-side pin model.
module tb_jtag_host;
  localparam int MAX_LEN = 16;
  localparam int CLK_DIV = 2;
  localparam int LW      = $clog2(MAX_LEN) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tck, tms, tdi, tdo;

  jtag_host_if #(.MAX_LEN(MAX_LEN), .LW(LW)) bus ();

  jtag_host #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  // TAP pin model: 0 = constant level, 1 = random per TCK, 2 = 1-bit bypass
  int   tdo_mode = 0;
  logic tdo_lvl  = 1'b0;
  logic rnd_bit  = 1'b0;
  logic byp      = 1'b0;
  logic byp_out  = 1'b0;
  int   rise_cnt = 0;
  bit   tms_q[$];
  bit   tdi_q[$];
  bit   tdo_q[$];

  assign tdo = (tdo_mode == 2) ? byp_out : (tdo_mode == 1) ? rnd_bit : tdo_lvl;

  always @(posedge tck) begin
    tms_q.push_back(tms);
    tdi_q.push_back(tdi);
    tdo_q.push_back(tdo);
    rise_cnt <= rise_cnt + 1;
    byp      <= tdi;
  end

  always @(negedge tck) begin
    byp_out <= byp;
    rnd_bit <= 1'($urandom);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one command (called at a negedge with cmd_ready high), wait for its
  // response and compare pin sequences against the command's TMS/TDI rules.
  // Returns at the negedge of the rsp_valid cycle with cmd_valid dropped.
  task automatic do_cmd(input logic [1:0] op, input int len, input logic [15:0] data,
                        input bit hold, output logic [15:0] got);
    int L, N, P, k;
    logic [63:0] etms, etdi, otms, otdi;
    logic [15:0] ersp;
    L = (len == 0) ? 1 : (len > MAX_LEN) ? MAX_LEN : len;
    case (op)
      2'b00:   begin N = 6;     P = 0; end
      2'b01:   begin N = 6 + L; P = 4; end
      2'b10:   begin N = 5 + L; P = 3; end
      default: begin N = L;     P = 0; end
    endcase
    etms = '0;
    etdi = '0;
    if (op == 2'b00) for (int i = 0; i < 5; i++) etms[i] = 1'b1;
    if (op == 2'b01) begin etms[0] = 1'b1; etms[1] = 1'b1; end
    if (op == 2'b10) etms[0] = 1'b1;
    if (op == 2'b01 || op == 2'b10) begin
      etms[P+L-1] = 1'b1;
      etms[P+L]   = 1'b1;
      for (int i = 0; i < L; i++) etdi[P+i] = data[i];
    end

    tms_q.delete(); tdi_q.delete(); tdo_q.delete();
    chk("ready_before", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LW'(len);
    bus.cmd_data  = data;
    @(posedge clk);
    k = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk("t1_busy", bus.busy, 1);
        chk("t1_ready", bus.cmd_ready, 0);
        chk("t1_tck", tck, 0);
        if (hold) begin
          bus.cmd_op   = 2'($urandom);
          bus.cmd_len  = LW'($urandom);
          bus.cmd_data = 16'($urandom);
        end else bus.cmd_valid = 1'b0;
      end
      if (bus.rsp_valid) break;
      @(posedge clk);
    end
    if (!bus.rsp_valid) chk("rsp_timeout", 1, 0);
    chk("latency", k, 1 + 2 * CLK_DIV * N);
    chk("done_ready", bus.cmd_ready, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_tck", tck, 0);
    chk("n_tck", tms_q.size(), N);
    otms = '0; otdi = '0;
    for (int i = 0; i < tms_q.size() && i < 64; i++) begin
      otms[i] = tms_q[i];
      otdi[i] = tdi_q[i];
    end
    chk("tms_seq", otms, etms);
    chk("tdi_seq", otdi, etdi);
    ersp = '0;
    if (op == 2'b01 || op == 2'b10)
      for (int i = 0; i < L; i++)
        if (P + i < tdo_q.size()) ersp[i] = tdo_q[P+i];
    chk("rsp_data", bus.rsp_data, ersp);
    got = bus.rsp_data;
    bus.cmd_valid = 1'b0;
  endtask

  // One cycle after a response with nothing new offered: parked pins, data held.
  task automatic idle_chk(input logic [15:0] held);
    @(negedge clk);
    chk("idle_rspv", bus.rsp_valid, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_pins", {tck, tms, tdi}, 3'b000);
    chk("idle_held", bus.rsp_data, held);
  endtask

  initial begin
    logic [15:0] got;
    int seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;

    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_pins", {tck, tms, tdi}, 3'b010);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rspv", bus.rsp_valid, 0);
    chk("rst_data", bus.rsp_data, 0);
    repeat (6) @(negedge clk);
    chk("no_tck_pre", rise_cnt, 0);
    chk("pre_tms", tms, 1);

    // TAP reset
    tdo_mode = 0; tdo_lvl = 1'b1;
    do_cmd(2'b00, 0, 16'hFFFF, 0, got);
    chk("tapreset_rsp", got, 16'h0000);
    idle_chk(got);

    // IR len 2 data 01
    do_cmd(2'b01, 2, 16'h0001, 0, got);
    idle_chk(got);

    // DR len 5, TDO tied high
    do_cmd(2'b10, 5, 16'h0000, 0, got);
    chk("dr_tdo1", got, 16'h001F);
    idle_chk(got);

    // DR len 5 through bypass model: data delayed one bit
    tdo_mode = 2;
    do_cmd(2'b10, 5, 16'b10110, 0, got);
    chk("dr_bypass", got, 16'b01100);
    idle_chk(got);

    // length clamps, valid held while busy, back-to-back chain
    tdo_mode = 1;
    do_cmd(2'b10, 0, 16'hFFFF, 1, got);
    do_cmd(2'b10, 31, 16'hA5C3, 1, got);
    do_cmd(2'b11, 3, 16'hFFFF, 0, got);
    idle_chk(got);

    // random commands, random chaining and holding
    for (int it = 0; it < 24; it++) begin
      logic [1:0] op;
      op       = 2'($urandom_range(0, 3));
      tdo_mode = $urandom_range(0, 1);
      tdo_lvl  = 1'($urandom);
      do_cmd(op, $urandom_range(0, 31), 16'($urandom), 1'($urandom), got);
      if ($urandom_range(0, 1) == 0) idle_chk(got);
    end
    idle_chk(got);

    // reset in the middle of a DR shift
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_len = LW'(16); bus.cmd_data = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2 * CLK_DIV * 6) @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_pins", {tck, tms, tdi}, 3'b010);
    chk("mid_rst_ready", bus.cmd_ready, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_data", bus.rsp_data, 0);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) seen++;
    end
    chk("mid_no_rsp", seen, 0);

    tdo_mode = 1;
    do_cmd(2'b00, 0, 16'h0, 0, got);
    do_cmd(2'b01, 7, 16'h005A, 0, got);
    idle_chk(got);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
